// File: rtl/izh_pkg.sv
// Shared types, constants and the sign-magnitude compare for the Izhikevich integrator.
// Words are sign-magnitude fixed point: bit N-1 is the sign, the rest the magnitude.
package izh_pkg;

    localparam int N = 32;
    localparam int Q = 16;

    typedef logic [N-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        INTEG,
        CHECK
    } state_t;

    localparam int    SIGN_BIT = N - 1;
    localparam word_t POS_ZERO = '0;
    localparam word_t POS_MAX  = {1'b0, {(N-1){1'b1}}};
    localparam word_t NEG_MAX  = {N{1'b1}};
    localparam word_t ONE      = word_t'(1) << Q;
    localparam word_t NEG_ONE  = ONE | (word_t'(1) << SIGN_BIT);

    // a >= b with -0 treated as +0
    function automatic logic smag_ge(input word_t a, input word_t b);
        logic [N-2:0] am;
        logic [N-2:0] bm;
        logic         an;
        logic         bn;
        am = a[N-2:0];
        bm = b[N-2:0];
        an = a[SIGN_BIT] && (am != '0);
        bn = b[SIGN_BIT] && (bm != '0);
        if (an != bn) begin
            return !an;
        end
        if (!an) begin
            return am >= bm;
        end
        return am <= bm;
    endfunction

endpackage

// File: rtl/smag_add_sat.sv
// Combinational saturating sign-magnitude adder.
// Magnitude overflow clamps to all-ones; a zero result is always +0.
module smag_add_sat #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    logic [N-2:0] am;
    logic [N-2:0] bm;
    logic [N-2:0] mag;
    logic [N-1:0] sum;
    logic         a_neg;
    logic         b_neg;
    logic         sgn;

    always_comb begin
        am    = a[N-2:0];
        bm    = b[N-2:0];
        a_neg = a[N-1] && (am != '0);
        b_neg = b[N-1] && (bm != '0);
        sum   = {1'b0, am} + {1'b0, bm};
        sgn   = a_neg;
        mag   = '0;
        if (a_neg == b_neg) begin
            mag = sum[N-1] ? '1 : sum[N-2:0];
        end else if (am >= bm) begin
            mag = am - bm;
        end else begin
            sgn = b_neg;
            mag = bm - am;
        end
        if (mag == '0) begin
            sgn = 1'b0;
        end
        y = {sgn, mag};
    end

endmodule

// File: rtl/izh_state_update.sv
// Izhikevich state integrator: Euler step, spike detect and post-spike reset.
// Define IZH_SPIKE_COUNT_EN to add a saturating 16-bit spike_count output.
module izh_state_update
    import izh_pkg::*;
#(
    parameter int N = izh_pkg::N,
    parameter int Q = izh_pkg::Q
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] v_init,
    input  logic [N-1:0] w_init,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dv,
    input  logic [N-1:0] dw,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    input  logic [N-1:0] v_th,
    output logic [N-1:0] v_out,
    output logic [N-1:0] w_out,
    output logic         spike,
    output logic         out_valid
`ifdef IZH_SPIKE_COUNT_EN
    ,
    output logic [15:0]  spike_count
`endif
);

    if (Q >= N) begin : g_bad_q
        $error("Q must be smaller than N");
    end

    state_t state_q, state_d;
    logic [N-1:0] v_q, v_d, w_q, w_d;
    logic [N-1:0] dv_q, dv_d, dw_q, dw_d;
    logic [N-1:0] vs_q, vs_d, ws_q, ws_d;
    logic spike_q, spike_d;
    logic out_valid_q, out_valid_d;
    logic [N-1:0] vs_sum, ws_sum, wd_sum;
`ifdef IZH_SPIKE_COUNT_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    smag_add_sat #(.N(N)) u_add_v (.a(v_q),  .b(dv_q), .y(vs_sum));
    smag_add_sat #(.N(N)) u_add_w (.a(w_q),  .b(dw_q), .y(ws_sum));
    smag_add_sat #(.N(N)) u_add_d (.a(ws_q), .b(d),    .y(wd_sum));

    assign in_ready  = (state_q == IDLE) && !load;
    assign v_out     = v_q;
    assign w_out     = w_q;
    assign spike     = spike_q;
    assign out_valid = out_valid_q;
`ifdef IZH_SPIKE_COUNT_EN
    assign spike_count = cnt_q;
`endif

    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        w_d         = w_q;
        dv_d        = dv_q;
        dw_d        = dw_q;
        vs_d        = vs_q;
        ws_d        = ws_q;
        spike_d     = spike_q;
        out_valid_d = 1'b0;
`ifdef IZH_SPIKE_COUNT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    v_d     = v_init;
                    w_d     = w_init;
                    spike_d = 1'b0;
`ifdef IZH_SPIKE_COUNT_EN
                    cnt_d   = '0;
`endif
                end else if (in_valid) begin
                    dv_d    = dv;
                    dw_d    = dw;
                    state_d = INTEG;
                end
            end
            INTEG: begin
                vs_d    = vs_sum;
                ws_d    = ws_sum;
                state_d = CHECK;
            end
            CHECK: begin
                if (smag_ge(vs_q, v_th)) begin
                    v_d     = c;
                    w_d     = wd_sum;
                    spike_d = 1'b1;
`ifdef IZH_SPIKE_COUNT_EN
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
`endif
                end else begin
                    v_d     = vs_q;
                    w_d     = ws_q;
                    spike_d = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            v_q         <= '0;
            w_q         <= '0;
            dv_q        <= '0;
            dw_q        <= '0;
            vs_q        <= '0;
            ws_q        <= '0;
            spike_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef IZH_SPIKE_COUNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            w_q         <= w_d;
            dv_q        <= dv_d;
            dw_q        <= dw_d;
            vs_q        <= vs_d;
            ws_q        <= ws_d;
            spike_q     <= spike_d;
            out_valid_q <= out_valid_d;
`ifdef IZH_SPIKE_COUNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_izh_state_update.sv
// Self-checking bench for izh_state_update against an arithmetic reference model.
module tb_izh_state_update;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] v_init = '0;
    logic [31:0] w_init = '0;
    logic [31:0] dv = '0;
    logic [31:0] dw = '0;
    logic [31:0] c = '0;
    logic [31:0] d = '0;
    logic [31:0] v_th = '0;
    logic        in_ready;
    logic [31:0] v_out;
    logic [31:0] w_out;
    logic        spike;
    logic        out_valid;
`ifdef IZH_SPIKE_COUNT_EN
    logic [15:0] spike_count;
`endif

    izh_state_update dut (
        .clk(clk), .rst(rst), .load(load),
        .v_init(v_init), .w_init(w_init),
        .in_valid(in_valid), .in_ready(in_ready),
        .dv(dv), .dw(dw), .c(c), .d(d), .v_th(v_th),
        .v_out(v_out), .w_out(w_out),
        .spike(spike), .out_valid(out_valid)
`ifdef IZH_SPIKE_COUNT_EN
        , .spike_count(spike_count)
`endif
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total = 0;
    bit chk_en = 1'b0;
    bit cnt_en = 1'b0;
    int hs_cnt = 0;
    int ov_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic longint to_int(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] from_int(input longint x);
        longint m;
        m = (x < 0) ? -x : x;
        if (m > 64'h7FFFFFFF) m = 64'h7FFFFFFF;
        return {(x < 0), m[30:0]};
    endfunction

    function automatic logic [31:0] m_add(input logic [31:0] a,
                                          input logic [31:0] b);
        return from_int(to_int(a) + to_int(b));
    endfunction

    logic [31:0] m_v = '0, m_w = '0, m_dv = '0, m_dw = '0;
    logic        m_spike = 1'b0, m_ov = 1'b0;
    int          m_phase = 0;
    int          m_cnt = 0;
    logic [31:0] m_vs, m_ws;
    logic        m_fire;

    assign m_vs   = m_add(m_v, m_dv);
    assign m_ws   = m_add(m_w, m_dw);
    assign m_fire = to_int(m_vs) >= to_int(v_th);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v <= '0; m_w <= '0; m_dv <= '0; m_dw <= '0;
            m_spike <= 1'b0; m_ov <= 1'b0; m_phase <= 0; m_cnt <= 0;
        end else begin
            m_ov <= 1'b0;
            if (m_phase == 0) begin
                if (load) begin
                    m_v <= v_init; m_w <= w_init;
                    m_spike <= 1'b0; m_cnt <= 0;
                end else if (in_valid) begin
                    m_dv <= dv; m_dw <= dw; m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                m_phase <= 2;
            end else begin
                m_v <= m_fire ? c : m_vs;
                m_w <= m_fire ? m_add(m_ws, d) : m_ws;
                m_spike <= m_fire;
                if (m_fire && m_cnt < 65535) m_cnt <= m_cnt + 1;
                m_ov <= 1'b1;
                m_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_ov);
            check("in_ready", in_ready, (m_phase == 0) && !load);
            check("v_out", v_out, m_v);
            check("w_out", w_out, m_w);
            check("spike", spike, m_spike);
`ifdef IZH_SPIKE_COUNT_EN
            check("spike_count", spike_count, m_cnt);
`endif
        end
        if (cnt_en) begin
            if (in_valid && in_ready) hs_cnt++;
            if (out_valid) ov_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] vi, input logic [31:0] wi);
        load = 1'b1; v_init = vi; w_init = wi;
        step();
        load = 1'b0;
    endtask

    task automatic wait_ov();
        for (int k = 0; k < 8 && !out_valid; k++) step();
        total++;
        if (out_valid) passes++;
        else $display("FAIL ov_timeout: got out_valid=0, expected pulse");
    endtask

    task automatic run(input logic [31:0] dvi, input logic [31:0] dwi);
        in_valid = 1'b1; dv = dvi; dw = dwi;
        step();
        in_valid = 1'b0;
        wait_ov();
    endtask

    initial begin
        step();
        chk_en = 1'b1;
        check("rst_v", v_out, 32'h0);
        check("rst_w", w_out, 32'h0);
        check("rst_spike", spike, 1'b0);
        check("rst_ov", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        rst = 1'b0;
        step();

        v_th = 32'h001E0000;
        do_load(32'h80410000, 32'h800D0000);
        run(32'h00050000, 32'h00010000);
        check("s1_v", v_out, 32'h803C0000);
        check("s1_w", w_out, 32'h800C0000);
        check("s1_spike", spike, 1'b0);
        step();

        c = 32'h80410000; d = 32'h00080000;
        do_load(32'h001C0000, 32'h00020000);
        run(32'h00020000, 32'h0);
        check("s2_spike", spike, 1'b1);
        check("s2_v", v_out, 32'h80410000);
        check("s2_w", w_out, 32'h000A0000);
        step();

        do_load(32'hFFFF0000, 32'h0);
        run(32'hFFFF0000, 32'h0);
        check("sat_v", v_out, 32'hFFFFFFFF);
        check("sat_spike", spike, 1'b0);
        step();
        do_load(32'h00010000, 32'h0);
        run(32'h80010000, 32'h0);
        check("zero_v", v_out, 32'h00000000);
        step();
        do_load(32'h80000000, 32'h80000000);
        run(32'h80000000, 32'h0);
        check("negzero_v", v_out, 32'h00000000);
        check("negzero_w", w_out, 32'h00000000);
        step();

        v_th = 32'h7FFFFFFF;
        do_load(32'h0, 32'h0);
        in_valid = 1'b1; dv = 32'h00000001; dw = 32'h0;
        hs_cnt = 0; ov_cnt = 0; cnt_en = 1'b1;
        repeat (9) step();
        in_valid = 1'b0;
        step();
        cnt_en = 1'b0;
        check("burst_hs", hs_cnt, 3);
        check("burst_ov", ov_cnt, 3);
        check("burst_v", v_out, 32'h00000003);

        in_valid = 1'b1; load = 1'b1; v_init = 32'h00050000; w_init = 32'h0;
        step();
        load = 1'b0; in_valid = 1'b0;
        repeat (4) step();
        check("load_wins_v", v_out, 32'h00050000);

        do_load(32'h00100000, 32'h00100000);
        in_valid = 1'b1; dv = 32'h00010000;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("midrst_v", v_out, 32'h0);
        check("midrst_w", w_out, 32'h0);
        check("midrst_ov", out_valid, 1'b0);
        step();
        rst = 1'b0;
        repeat (4) step();

`ifdef IZH_SPIKE_COUNT_EN
        c = 32'h001C0000; d = 32'h0; v_th = 32'h001E0000;
        do_load(32'h001C0000, 32'h0);
        repeat (3) begin
            run(32'h00020000, 32'h0);
            step();
        end
        check("cnt3", spike_count, 16'd3);
        do_load(32'h0, 32'h0);
        check("cnt_clr", spike_count, 16'd0);
`endif

        step();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
